// File: rtl/wb_cmd_master_pkg.sv
// wb_cmd_master_pkg: shared state, command and response types for the Wishbone command master
package wb_cmd_master_pkg;
  localparam int ADR_MAX = 64;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;
  typedef struct packed {
    logic              we;
    logic [ADR_MAX-1:0] adr;
    logic [31:0]       dat;
    logic [3:0]        sel;
  } cmd_t;
  typedef struct packed {
    logic [31:0] dat;
    logic        err;
    logic        tmo;
  } rsp_t;
endpackage

// File: rtl/wb_cmd_timer.sv
// wb_cmd_timer: loadable down-counter, expiry flagged while enabled on its last count
module wb_cmd_timer #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [W-1:0] val_i,
  output logic         exp_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : load_i ? val_i : (en_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign exp_o = en_i && cnt_q == W'(1);
endmodule

// File: rtl/wb_cmd_master.sv
// wb_cmd_master: single-outstanding Wishbone pipelined initiator fed by a valid/ready command stream
module wb_cmd_master
  import wb_cmd_master_pkg::*;
#(
  parameter int ADR_WIDTH = 32,
  parameter int TIMEOUT   = 255,
  parameter int MAX_RETRY = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic                 cmd_we_i,
  input  logic [ADR_WIDTH-1:0] cmd_adr_i,
  input  logic [31:0]          cmd_dat_i,
  input  logic [3:0]           cmd_sel_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [31:0]          rsp_dat_o,
  output logic                 rsp_err_o,
  output logic                 rsp_tmo_o,
  output logic                 wb_cyc_o,
  output logic                 wb_stb_o,
  output logic                 wb_we_o,
  output logic [ADR_WIDTH-1:0] wb_adr_o,
  output logic [3:0]           wb_sel_o,
  output logic [31:0]          wb_dat_o,
  input  logic                 wb_ack_i,
  input  logic                 wb_err_i,
  input  logic                 wb_rty_i,
  input  logic                 wb_stall_i,
  input  logic [31:0]          wb_dat_i
);
  localparam int RW = $clog2(MAX_RETRY + 1) + 1;
  state_e        state_q, state_d;
  cmd_t          cmd_q, cmd_d;
  rsp_t          rsp_q, rsp_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          cyc_q, cyc_d, stb_q, stb_d, rsp_valid_q, rsp_valid_d, cmd_ready_q, cmd_ready_d;
  logic          busy, load, clr, tmr_exp;
  wb_cmd_timer #(.W(16)) u_timer (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (clr),
    .load_i(load),
    .en_i  (busy),
    .val_i (16'(TIMEOUT)),
    .exp_o (tmr_exp)
  );
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    rsp_d   = rsp_q;
    retry_d = retry_q;
    load    = 1'b0;
    busy    = state_q == REQ || state_q == WAIT;
    if (state_q == IDLE && cmd_valid_i && cmd_ready_q) begin
      state_d = REQ;
      cmd_d   = '{we: cmd_we_i, adr: ADR_MAX'(cmd_adr_i), dat: cmd_we_i ? cmd_dat_i : 32'h0, sel: cmd_sel_i};
      rsp_d   = '0;
      retry_d = '0;
      load    = 1'b1;
    end else if (busy) begin
      // err > ack > rty, and any bus response beats a simultaneous timeout
      if (wb_err_i) begin
        state_d = RESP;
        rsp_d   = '{dat: 32'h0, err: 1'b1, tmo: 1'b0};
      end else if (wb_ack_i) begin
        state_d = RESP;
        rsp_d   = '{dat: cmd_q.we ? 32'h0 : wb_dat_i, err: 1'b0, tmo: 1'b0};
      end else if (wb_rty_i && retry_q < RW'(MAX_RETRY)) begin
        state_d = REQ;
        retry_d = retry_q + 1'b1;
        load    = 1'b1;
      end else if (wb_rty_i || tmr_exp) begin
        state_d = RESP;
        rsp_d   = '{dat: 32'h0, err: 1'b1, tmo: !wb_rty_i};
      end else if (state_q == REQ && !wb_stall_i) begin
        state_d = WAIT;
      end
    end else if (state_q == RESP && rsp_ready_i) begin
      state_d = IDLE;
    end
    clr         = !(state_d == REQ || state_d == WAIT);
    cyc_d       = state_d == REQ || state_d == WAIT;
    stb_d       = state_d == REQ;
    rsp_valid_d = state_d == RESP;
    cmd_ready_d = state_d == IDLE;
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      rsp_q       <= '0;
      retry_q     <= '0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      cmd_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      rsp_q       <= rsp_d;
      retry_q     <= retry_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      rsp_valid_q <= rsp_valid_d;
      cmd_ready_q <= cmd_ready_d;
    end
  assign cmd_ready_o = cmd_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_dat_o   = rsp_q.dat;
  assign rsp_err_o   = rsp_q.err;
  assign rsp_tmo_o   = rsp_q.tmo;
  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = stb_q;
  assign wb_we_o     = cmd_q.we;
  assign wb_adr_o    = ADR_WIDTH'(cmd_q.adr);
  assign wb_sel_o    = cmd_q.sel;
  assign wb_dat_o    = cmd_q.dat;
endmodule

// File: tb/tb_wb_cmd_master.sv
// tb_wb_cmd_master: directed and randomized checks of wb_cmd_master against a bench-side slave and word model
module tb_wb_cmd_master;
  localparam int TMO = 16;
  localparam int MR  = 3;
  logic        clk = 1'b0, rst_i = 1'b1;
  logic        cmd_valid_i = 0, cmd_ready_o, cmd_we_i = 0;
  logic [31:0] cmd_adr_i = 0, cmd_dat_i = 0;
  logic [3:0]  cmd_sel_i = 0;
  logic        rsp_valid_o, rsp_ready_i = 0, rsp_err_o, rsp_tmo_o;
  logic [31:0] rsp_dat_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_ack_i = 0, wb_err_i = 0, wb_rty_i = 0, wb_stall_i = 0;
  logic [31:0] wb_dat_i = 0;
  int npass = 0, nfail = 0, ntot = 0;
  // slave configuration: mode 0 pipelined, 1 stall-until-ack, 2 silent, 3 error
  int s_mode = 0, s_stall = 0, s_ack_dly = 1, s_rty_left = 0;
  logic s_stray = 0;
  int scnt = 0, wcnt = 0, n_phase = 0, n_win = 0, n_stb_cyc = 0, n_wait = 0, n_cyc_cyc = 0;
  logic prev_cyc = 0, prev_stb = 0;
  logic [31:0] bank [16];
  logic [31:0] ref_mem [16];
  logic [31:0] l_adr, l_dat;
  logic [3:0]  l_sel;
  wb_cmd_master #(.ADR_WIDTH(32), .TIMEOUT(TMO), .MAX_RETRY(MR)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i), .cmd_sel_i(cmd_sel_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_dat_o(rsp_dat_o),
    .rsp_err_o(rsp_err_o), .rsp_tmo_o(rsp_tmo_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
    .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .wb_rty_i(wb_rty_i), .wb_stall_i(wb_stall_i), .wb_dat_i(wb_dat_i)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntot++;
    assert (got === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task respond;
    if (s_rty_left > 0) begin
      wb_rty_i = 1;
      s_rty_left--;
    end else if (s_mode == 3) wb_err_i = 1;
    else if (s_mode != 2) begin
      wb_ack_i = 1;
      l_adr = wb_adr_o;
      l_dat = wb_dat_o;
      l_sel = wb_sel_o;
      if (wb_we_o) begin
        for (int b = 0; b < 4; b++)
          if (wb_sel_o[b]) bank[wb_adr_o[5:2]][8*b +: 8] = wb_dat_o[8*b +: 8];
        wb_dat_i = 32'hFFFF_FFFF;
      end else wb_dat_i = bank[wb_adr_o[5:2]];
    end
  endtask
  // bus slave: reacts to registered master outputs at the falling edge
  always @(negedge clk) begin
    wb_ack_i = 0; wb_err_i = 0; wb_rty_i = 0; wb_stall_i = 0; wb_dat_i = 0;
    if (s_stray) begin
      wb_ack_i = 1; wb_err_i = 1; wb_rty_i = 1; wb_dat_i = 32'hBAD0BAD0;
    end else if (wb_cyc_o) begin
      n_cyc_cyc++;
      if (!prev_cyc) n_win++;
      if (wb_stb_o) begin
        n_stb_cyc++;
        if (!prev_stb) begin n_phase++; scnt = 0; end
        if (s_mode == 1) begin
          wb_stall_i = 1;
          if (scnt == s_stall) respond();
          scnt++;
        end else if (scnt < s_stall) begin
          wb_stall_i = 1;
          scnt++;
        end else wcnt = 0;
      end else begin
        n_wait++;
        wcnt++;
        if (wcnt == s_ack_dly) respond();
      end
    end
    prev_cyc = wb_cyc_o;
    prev_stb = wb_stb_o;
  end
  task automatic wait_ready();
    int t = 0;
    while (!cmd_ready_o && t < 100) begin @(negedge clk); t++; end
    chk("ready_bound", 32'(t < 100), 1);
  endtask
  task automatic wait_rsp();
    int t = 0;
    while (!rsp_valid_o && t < 200) begin @(negedge clk); t++; end
    chk("rsp_bound", 32'(t < 200), 1);
  endtask
  task automatic run_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                         output logic [31:0] r_dat, output logic r_err, output logic r_tmo);
    n_phase = 0; n_win = 0; n_stb_cyc = 0; n_wait = 0; n_cyc_cyc = 0;
    wait_ready();
    cmd_valid_i = 1; cmd_we_i = we; cmd_adr_i = adr; cmd_dat_i = dat; cmd_sel_i = sel;
    @(negedge clk);
    cmd_valid_i = 0;
    wait_rsp();
    r_dat = rsp_dat_o; r_err = rsp_err_o; r_tmo = rsp_tmo_o;
    rsp_ready_i = 1;
    @(negedge clk);
    rsp_ready_i = 0;
  endtask
  task automatic set_slave(input int mode, input int stall, input int dly, input int rty);
    s_mode = mode; s_stall = stall; s_ack_dly = dly; s_rty_left = rty;
  endtask
  initial begin
    logic [31:0] d, d0, wd;
    logic e, tm, we;
    logic [3:0] sel;
    int k, idx, mode, rty, exp_err;
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] d, d0, wd;
    logic e, tm, we;
    logic [3:0] sel;
    int k, idx, mode, rty, exp_err;
    for (int i = 0; i < 16; i++) begin bank[i] = 0; ref_mem[i] = 0; end
    #12;
    chk("rst_cmd_ready", 32'(cmd_ready_o), 0);
    chk("rst_cyc", 32'({wb_cyc_o, wb_stb_o, rsp_valid_o}), 0);
    chk("rst_wb_outs", {wb_adr_o[27:0], wb_sel_o}, 0);
    @(negedge clk); rst_i = 0;
    @(negedge clk);
    chk("ready_after_rst", 32'(cmd_ready_o), 1);
    // write with one stall cycle, ack two cycles later, then read back
    set_slave(0, 1, 2, 0);
    run_txn(1, 32'h0, 32'hDEADBEEF, 4'hF, d, e, tm);
    ref_mem[0] = 32'hDEADBEEF;
    chk("wr_rsp", {d[29:0], e, tm}, 0);
    chk("wr_win", n_win, 1);
    chk("wr_stb_cycles", n_stb_cyc, 2);
    chk("wr_wait_cycles", n_wait, 2);
    run_txn(0, 32'h0, 32'h0, 4'hF, d, e, tm);
    chk("rd_back", d, 32'hDEADBEEF);
    chk("rd_back_err", {e, tm}, 0);
    // stall-until-ack slave answers while stb is still high
    bank[3] = 32'h12345678; ref_mem[3] = 32'h12345678;
    set_slave(1, 2, 1, 0);
    run_txn(0, 32'hC, 32'h5555_5555, 4'hF, d, e, tm);
    chk("stallack_dat", d, 32'h12345678);
    chk("stallack_err", {e, tm}, 0);
    chk("stallack_nowait", n_wait, 0);
    chk("stallack_wbdat_rd", l_dat, 0);
    // retries: two then ack, four then error
    set_slave(0, 0, 1, 2);
    run_txn(0, 32'hC, 32'h0, 4'hF, d, e, tm);
    chk("rty2_phases", n_phase, 3);
    chk("rty2_rsp", {d, e, tm}, {32'h12345678, 2'b00});
    set_slave(0, 0, 1, 4);
    run_txn(0, 32'hC, 32'h0, 4'hF, d, e, tm);
    chk("rty4_phases", n_phase, 4);
    chk("rty4_rsp", {d[29:0], e, tm}, 2'b10);
    // silent slave times out, stray responses later are ignored
    set_slave(2, 0, 1, 0);
    run_txn(0, 32'h8, 32'h0, 4'hF, d, e, tm);
    chk("tmo_cyc_len", n_cyc_cyc, TMO);
    chk("tmo_rsp", {d[29:0], e, tm}, 2'b11);
    s_stray = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stray_ignored", {29'h0, wb_cyc_o, rsp_valid_o, cmd_ready_o}, 1);
    end
    s_stray = 0;
    @(negedge clk); @(negedge clk);
    chk("stray_idle", {30'h0, rsp_valid_o, cmd_ready_o}, 1);
    // response back-pressure with a new command waiting
    set_slave(0, 0, 1, 0);
    wait_ready();
    cmd_valid_i = 1; cmd_we_i = 0; cmd_adr_i = 32'hC; cmd_sel_i = 4'hF;
    wait_rsp();
    d0 = rsp_dat_o;
    chk("bp_dat", d0, ref_mem[3]);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold", {rsp_dat_o, rsp_valid_o, cmd_ready_o, rsp_err_o}, {d0, 3'b100});
    end
    rsp_ready_i = 1;
    @(negedge clk);
    rsp_ready_i = 0;
    k = 1;
    while (!wb_cyc_o && k < 10) begin @(negedge clk); k++; end
    cmd_valid_i = 0;
    chk("bp_next_start", k, 2);
    wait_rsp();
    chk("bp_second", {rsp_dat_o, rsp_err_o}, {ref_mem[3], 1'b0});
    rsp_ready_i = 1; @(negedge clk); rsp_ready_i = 0;
    // asynchronous reset while waiting for a silent slave
    set_slave(2, 0, 1, 0);
    wait_ready();
    cmd_valid_i = 1; cmd_we_i = 1; cmd_adr_i = 32'h14; cmd_dat_i = 32'hCAFEF00D; cmd_sel_i = 4'hF;
    @(negedge clk); cmd_valid_i = 0;
    k = 0;
    while (!(wb_cyc_o && !wb_stb_o) && k < 20) begin @(negedge clk); k++; end
    chk("rst_reach_wait", 32'(k < 20), 1);
    #2 rst_i = 1;
    #1 chk("async_rst", {28'h0, wb_cyc_o, wb_stb_o, rsp_valid_o, cmd_ready_o}, 0);
    @(negedge clk); rst_i = 0; s_mode = 0;
    @(negedge clk);
    chk("ready_after_rst2", 32'(cmd_ready_o), 1);
    run_txn(0, 32'h14, 32'h0, 4'hF, d, e, tm);
    chk("fresh_read", {d, e, tm}, {ref_mem[5], 2'b00});
    // randomized traffic against the word model
    for (int n = 0; n < 40; n++) begin
      we = 1'($urandom_range(0, 1));
      idx = $urandom_range(0, 15);
      wd = $urandom;
      sel = 4'($urandom_range(1, 15));
      mode = $urandom_range(0, 5);
      mode = mode == 5 ? 3 : mode == 4 ? 1 : 0;
      rty = (mode == 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      set_slave(mode, $urandom_range(0, 2), $urandom_range(1, 3), rty);
      run_txn(we, 32'(idx * 4), wd, sel, d, e, tm);
      exp_err = (mode == 3 || rty > MR) ? 1 : 0;
      chk("rnd_err", {30'h0, e, tm}, 32'(exp_err << 1));
      chk("rnd_phases", n_phase, mode == 3 ? 1 : (rty > MR ? MR : rty) + 1);
      if (we && exp_err == 0)
        for (int b = 0; b < 4; b++) if (sel[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
      chk("rnd_dat", d, (!we && exp_err == 0) ? ref_mem[idx] : 32'h0);
      if (exp_err == 0) chk("rnd_bus", {l_adr[7:0], l_sel, 20'h0}, {8'(idx * 4), sel, 20'h0});
      if (exp_err == 0) chk("rnd_wbdat", l_dat, we ? wd : 32'h0);
    end
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
